vend_txn_ctrl: RTL and testbench

- Transaction sequencer for the vending item_memory.
- Owns every item_memory control input (we, dispense_valid, waddr, dispensed_item, count, price) and reads back item_data_out.
- Handles two activities: operator configuration writes, and customer purchases (select, coin collection, dispense, change).
- Sits between the front-panel/coin logic and item_memory. It is the only block that drives item_memory.

---
 rtl/vend_txn_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_vend_txn_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_txn_ctrl.sv
// -----------------------------------------------------------------------------
// vend_txn_ctrl
//
// Transaction sequencer for the vending item_memory. It is the only block that
// drives item_memory. It handles two activities: operator configuration writes,
// and customer purchases (select, coin collection, dispense, change).
//
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   cfg_valid/addr/       configuration write request: slot, stock count and
//   count/price           price to load
//   sel_valid/addr        customer item select
//   coin_valid/value      coin inserted and its value
//   cancel                customer cancel
//   mem_*                 item_memory write/dispense controls (registered)
//   mem_rdata             item_memory read data
//                         {dispensed[31:24], count[23:16], price[15:0]},
//                         valid one cycle after mem_waddr is driven
//   busy                  high whenever the sequencer is not idle
//   balance               credit currently held
//   dispense_pulse        one-cycle pulse when an item is vended
//   change_valid/amount   one-cycle change or refund (amount is 0 otherwise)
//   coin_reject           one-cycle pulse: the coin is returned
//   err_sold_out          one-cycle pulse: selected item has count 0
//   err_invalid           one-cycle pulse: selected item has price 0
//
// Every output is a register loaded from the next-state logic, so an output
// described as "high in state X" is high during the cycle the FSM sits in X.
// -----------------------------------------------------------------------------
module vend_txn_ctrl #(
  parameter int MAX_ITEMS      = 1024,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int ADDR_W        = $clog2(MAX_ITEMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_count,
  input  logic [15:0]       cfg_price,
  input  logic              sel_valid,
  input  logic [ADDR_W-1:0] sel_addr,
  input  logic              coin_valid,
  input  logic [15:0]       coin_value,
  input  logic              cancel,
  output logic              mem_we,
  output logic              mem_dispense_valid,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_dispensed_item,
  output logic [7:0]        mem_count,
  output logic [15:0]       mem_price,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [15:0]       balance,
  output logic              dispense_pulse,
  output logic              change_valid,
  output logic [15:0]       change_amount,
  output logic              coin_reject,
  output logic              err_sold_out,
  output logic              err_invalid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // The timer counts down from TIMEOUT_CYCLES-1 to 0, so the refund fires on
  // the TIMEOUT_CYCLES-th coinless cycle spent in COLLECT.
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_READ,
    S_CHECK,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] item_q, item_d;
  logic [15:0]       price_q, price_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [15:0]       balance_d;

  logic              mem_we_d, mem_dv_d;
  logic [ADDR_W-1:0] mem_waddr_d;
  logic [7:0]        mem_ditem_d, mem_count_d;
  logic [15:0]       mem_price_d;
  logic              dispense_d, change_valid_d, coin_reject_d;
  logic [15:0]       change_amount_d;
  logic              err_sold_out_d, err_invalid_d;

  logic [16:0]       coin_sum;
  logic [15:0]       credit;
  logic              coin_ok, timed_out;
  logic [15:0]       rd_price;
  logic [7:0]        rd_count;
  logic              unused_rdata;

  assign rd_price     = mem_rdata[15:0];
  assign rd_count     = mem_rdata[23:16];
  assign unused_rdata = ^mem_rdata[31:24];
  // One extra bit exposes a balance overflow as the carry.
  assign coin_sum     = {1'b0, balance} + {1'b0, coin_value};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_d         = state_q;
    item_d          = item_q;
    price_d         = price_q;
    timer_d         = timer_q;
    balance_d       = balance;
    mem_we_d        = 1'b0;
    mem_dv_d        = 1'b0;
    mem_waddr_d     = mem_waddr;
    mem_ditem_d     = 8'd0;
    mem_count_d     = 8'd0;
    mem_price_d     = 16'd0;
    dispense_d      = 1'b0;
    change_valid_d  = 1'b0;
    change_amount_d = 16'd0;
    coin_reject_d   = coin_valid && (state_q != S_COLLECT);
    err_sold_out_d  = 1'b0;
    err_invalid_d   = 1'b0;
    coin_ok         = 1'b0;
    timed_out       = 1'b0;
    credit          = balance;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          state_d     = S_CFG;
          mem_we_d    = 1'b1;
          mem_waddr_d = cfg_addr;
          mem_count_d = cfg_count;
          mem_price_d = cfg_price;
        end else if (sel_valid) begin
          state_d     = S_READ;
          item_d      = sel_addr;
          mem_waddr_d = sel_addr;
        end
      end

      S_CFG:  state_d = S_IDLE;

      // The registered read of item_memory lands during CHECK.
      S_READ: state_d = S_CHECK;

      S_CHECK: begin
        if (rd_price == 16'd0) begin
          err_invalid_d = 1'b1;
          state_d       = S_IDLE;
        end else if (rd_count == 8'd0) begin
          err_sold_out_d = 1'b1;
          state_d        = S_IDLE;
        end else begin
          price_d   = rd_price;
          timer_d   = TIMER_RELOAD;
          balance_d = 16'd0;
          state_d   = S_COLLECT;
        end
      end

      S_COLLECT: begin
        coin_ok       = coin_valid && !coin_sum[16];
        coin_reject_d = coin_valid && coin_sum[16];
        if (coin_ok) begin
          credit = coin_sum[15:0];
        end
        timed_out = !coin_ok && (timer_q == '0);
        timer_d   = coin_ok ? TIMER_RELOAD : timer_q - TW'(1);
        // A coin arriving with cancel is credited first and then refunded,
        // so cancel beats completion.
        if (cancel || timed_out) begin
          balance_d = 16'd0;
          if (credit != 16'd0) begin
            state_d         = S_CHANGE;
            change_valid_d  = 1'b1;
            change_amount_d = credit;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          balance_d = credit;
          if (credit >= price_q) begin
            state_d     = S_DISPENSE;
            mem_dv_d    = 1'b1;
            mem_waddr_d = item_q;
            dispense_d  = 1'b1;
          end
        end
      end

      S_DISPENSE: begin
        balance_d = 16'd0;
        if (balance != price_q) begin
          state_d         = S_CHANGE;
          change_valid_d  = 1'b1;
          change_amount_d = balance - price_q;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CHANGE: state_d = S_IDLE;

      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      item_q             <= '0;
      price_q            <= 16'd0;
      timer_q            <= '0;
      balance            <= 16'd0;
      mem_we             <= 1'b0;
      mem_dispense_valid <= 1'b0;
      mem_waddr          <= '0;
      mem_dispensed_item <= 8'd0;
      mem_count          <= 8'd0;
      mem_price          <= 16'd0;
      busy               <= 1'b0;
      dispense_pulse     <= 1'b0;
      change_valid       <= 1'b0;
      change_amount      <= 16'd0;
      coin_reject        <= 1'b0;
      err_sold_out       <= 1'b0;
      err_invalid        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q            <= state_d;
      item_q             <= item_d;
      price_q            <= price_d;
      timer_q            <= timer_d;
      balance            <= balance_d;
      mem_we             <= mem_we_d;
      mem_dispense_valid <= mem_dv_d;
      mem_waddr          <= mem_waddr_d;
      mem_dispensed_item <= mem_ditem_d;
      mem_count          <= mem_count_d;
      mem_price          <= mem_price_d;
      busy               <= (state_d != S_IDLE);
      dispense_pulse     <= dispense_d;
      change_valid       <= change_valid_d;
      change_amount      <= change_amount_d;
      coin_reject        <= coin_reject_d;
      err_sold_out       <= err_sold_out_d;
      err_invalid        <= err_invalid_d;
    end
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_txn_ctrl
//
// Stimulus tasks drive configuration writes and purchases and push the
// expected responses (computed from a transaction-level model of stock,
// prices and credit) into per-event queues. A monitor on the falling edge pops
// and compares whenever the DUT raises an event output. A behavioural
// item_memory with a registered read provides mem_rdata.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vend_txn_ctrl;

  localparam int MAX_ITEMS = 16;
  localparam int TIMEOUT   = 8;
  localparam int AW        = $clog2(MAX_ITEMS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [7:0]    cfg_count = '0;
  logic [15:0]   cfg_price = '0;
  logic          sel_valid = 1'b0;
  logic [AW-1:0] sel_addr = '0;
  logic          coin_valid = 1'b0;
  logic [15:0]   coin_value = '0;
  logic          cancel = 1'b0;
  logic          mem_we, mem_dispense_valid;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_dispensed_item, mem_count;
  logic [15:0]   mem_price;
  logic [31:0]   mem_rdata = '0;
  logic          busy, dispense_pulse, change_valid, coin_reject;
  logic          err_sold_out, err_invalid;
  logic [15:0]   balance, change_amount;

  always #5 clk = ~clk;

  vend_txn_ctrl #(.MAX_ITEMS(MAX_ITEMS), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_count(cfg_count), .cfg_price(cfg_price),
    .sel_valid(sel_valid), .sel_addr(sel_addr),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .mem_we(mem_we), .mem_dispense_valid(mem_dispense_valid), .mem_waddr(mem_waddr),
    .mem_dispensed_item(mem_dispensed_item), .mem_count(mem_count), .mem_price(mem_price),
    .mem_rdata(mem_rdata), .busy(busy), .balance(balance),
    .dispense_pulse(dispense_pulse), .change_valid(change_valid),
    .change_amount(change_amount), .coin_reject(coin_reject),
    .err_sold_out(err_sold_out), .err_invalid(err_invalid)
  );

  // Behavioural item_memory: registered read, write on we, decrement on dispense.
  logic [7:0]  m_cnt [MAX_ITEMS] = '{default: '0};
  logic [15:0] m_prc [MAX_ITEMS] = '{default: '0};
  logic [7:0]  m_dsp [MAX_ITEMS] = '{default: '0};

  always @(posedge clk) begin
    if (mem_we) begin
      m_cnt[mem_waddr] <= mem_count;
      m_prc[mem_waddr] <= mem_price;
      m_dsp[mem_waddr] <= mem_dispensed_item;
    end else if (mem_dispense_valid) begin
      m_cnt[mem_waddr] <= m_cnt[mem_waddr] - 8'd1;
      m_dsp[mem_waddr] <= m_dsp[mem_waddr] + 8'd1;
    end
    mem_rdata <= {m_dsp[mem_waddr], m_cnt[mem_waddr], m_prc[mem_waddr]};
  end

  // Reference model state and expectation queues.
  typedef struct { int addr; int cnt; int prc; } cfg_t;
  int   ref_cnt [MAX_ITEMS] = '{default: 0};
  int   ref_prc [MAX_ITEMS] = '{default: 0};
  cfg_t q_cfg[$];
  int   q_disp[$];
  int   q_chg[$];
  int   q_rej[$];
  int   q_sold[$];
  int   q_inv[$];
  int   plan[$];

  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pop an expectation whenever the DUT presents an event.
  cfg_t mon_cfg;
  int   mon_v;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (q_cfg.size() == 0) check("unexpected_cfg_write", mem_we, 0);
        else begin
          mon_cfg = q_cfg.pop_front();
          check("cfg_waddr", mem_waddr, mon_cfg.addr);
          check("cfg_count", mem_count, mon_cfg.cnt);
          check("cfg_price", mem_price, mon_cfg.prc);
          check("cfg_dispensed_item", mem_dispensed_item, 0);
        end
      end
      if (mem_dispense_valid) begin
        if (q_disp.size() == 0) check("unexpected_dispense", mem_dispense_valid, 0);
        else begin
          mon_v = q_disp.pop_front();
          check("dispense_waddr", mem_waddr, mon_v);
          check("dispense_pulse", dispense_pulse, 1);
        end
      end else begin
        check("dispense_pulse_idle", dispense_pulse, 0);
      end
      if (mem_we || mem_dispense_valid)
        check("we_dv_exclusive", mem_we & mem_dispense_valid, 0);
      if (change_valid) begin
        if (q_chg.size() == 0) check("unexpected_change", change_valid, 0);
        else begin
          mon_v = q_chg.pop_front();
          check("change_amount", change_amount, mon_v);
        end
      end else begin
        check("change_amount_idle", change_amount, 0);
      end
      if (coin_reject) begin
        if (q_rej.size() == 0) check("unexpected_coin_reject", coin_reject, 0);
        else mon_v = q_rej.pop_front();
      end
      if (err_sold_out) begin
        if (q_sold.size() == 0) check("unexpected_sold_out", err_sold_out, 0);
        else mon_v = q_sold.pop_front();
      end
      if (err_invalid) begin
        if (q_inv.size() == 0) check("unexpected_invalid", err_invalid, 0);
        else mon_v = q_inv.pop_front();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("return_to_idle", busy, 0);
  endtask

  task automatic set_plan(input int n, input int c0 = 0, input int c1 = 0, input int c2 = 0);
    plan.delete();
    if (n > 0) plan.push_back(c0);
    if (n > 1) plan.push_back(c1);
    if (n > 2) plan.push_back(c2);
  endtask

  task automatic do_cfg(input int addr, input int cnt, input int prc);
    cfg_t e;
    e.addr = addr; e.cnt = cnt; e.prc = prc;
    q_cfg.push_back(e);
    ref_cnt[addr] = cnt;
    ref_prc[addr] = prc;
    cfg_valid = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_count = 8'(cnt);
    cfg_price = 16'(prc);
    tick();
    cfg_valid = 1'b0;
    wait_idle(8);
  endtask

  // end_mode: 0 = let it time out, 1 = cancel with the last coin, 2 = cancel after.
  task automatic purchase(input int addr, input int end_mode);
    int bal = 0;
    int price;
    bit done = 0;
    bit last_cancel;
    price = ref_prc[addr];
    if (price == 0) q_inv.push_back(addr);
    else if (ref_cnt[addr] == 0) q_sold.push_back(addr);
    sel_valid = 1'b1;
    sel_addr  = AW'(addr);
    tick();
    sel_valid = 1'b0;
    tick();
    tick();
    if (price == 0 || ref_cnt[addr] == 0) begin
      wait_idle(8);
      return;
    end
    for (int i = 0; i < plan.size() && !done; i++) begin
      last_cancel = (end_mode == 1) && (i == plan.size() - 1);
      coin_valid  = 1'b1;
      coin_value  = 16'(plan[i]);
      cancel      = last_cancel;
      if (bal + plan[i] > 65535) q_rej.push_back(1);
      else bal += plan[i];
      if (last_cancel) begin
        if (bal > 0) q_chg.push_back(bal);
        done = 1;
      end else if (bal >= price) begin
        q_disp.push_back(addr);
        ref_cnt[addr]--;
        if (bal > price) q_chg.push_back(bal - price);
        done = 1;
      end
      tick();
      coin_valid = 1'b0;
      cancel     = 1'b0;
      if (!done) repeat ($urandom_range(0, 2)) tick();
    end
    if (!done) begin
      if (end_mode == 2) begin
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
      end
      if (bal > 0) q_chg.push_back(bal);
    end
    wait_idle(TIMEOUT + 32);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int coin_tbl[5] = '{5, 10, 20, 25, 50};
  int n;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_outputs",
          {mem_we, mem_dispense_valid, mem_waddr, mem_dispensed_item, mem_count, mem_price,
           busy, balance, dispense_pulse, change_valid, change_amount, coin_reject,
           err_sold_out, err_invalid}, 0);

    // Basic purchase with change.
    do_cfg(3, 2, 30);
    set_plan(2, 20, 20);  purchase(3, 0);
    // Exact payment, then sold out, then unconfigured item.
    do_cfg(5, 1, 20);
    set_plan(1, 20);      purchase(5, 0);
    set_plan(0);          purchase(5, 0);
    set_plan(0);          purchase(7, 0);
    // Cancel in the same cycle as a coin: coin credited, all refunded.
    set_plan(2, 10, 5);   purchase(3, 1);

    // Timeout refund after TIMEOUT coinless cycles.
    sel_valid = 1'b1; sel_addr = AW'(3);
    tick(); sel_valid = 1'b0; tick(); tick();
    q_chg.push_back(10);
    coin_valid = 1'b1; coin_value = 16'd10;
    tick(); coin_valid = 1'b0;
    n = 0;
    while (!change_valid && n < 40) begin tick(); n++; end
    check("timeout_cycles", n, TIMEOUT);
    wait_idle(8);

    // Coin while idle is rejected and leaves balance at 0.
    q_rej.push_back(1);
    coin_valid = 1'b1; coin_value = 16'd25;
    tick(); coin_valid = 1'b0;
    check("idle_coin_balance", balance, 0);
    tick();

    // Reset in COLLECT discards credit with no refund.
    sel_valid = 1'b1; sel_addr = AW'(3);
    tick(); sel_valid = 1'b0; tick(); tick();
    coin_valid = 1'b1; coin_value = 16'd10;
    tick(); coin_valid = 1'b0;
    check("balance_before_reset", balance, 10);
    rst = 1'b1;
    #2;
    check("reset_mid_balance", balance, 0);
    check("reset_mid_busy", busy, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // cfg_valid and sel_valid together: the write wins, the select is dropped.
    sel_valid = 1'b1; sel_addr = AW'(7);
    do_cfg(9, 1, 40);
    sel_valid = 1'b0;
    set_plan(1, 40);      purchase(9, 0);

    // Overflowing coin is rejected, then an exact top-up completes.
    do_cfg(10, 1, 65535);
    set_plan(3, 32768, 32768, 32767); purchase(10, 0);

    // Randomized mix of configuration writes and purchases.
    for (int t = 0; t < 60; t++) begin
      int addr = $urandom_range(0, MAX_ITEMS - 1);
      if ($urandom_range(0, 3) == 0) begin
        do_cfg(addr, $urandom_range(0, 3),
               ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(5, 100));
      end else begin
        plan.delete();
        repeat ($urandom_range(0, 5)) plan.push_back(coin_tbl[$urandom_range(0, 4)]);
        purchase(addr, $urandom_range(0, 2));
      end
    end

    repeat (4) tick();
    check("pending_cfg",  q_cfg.size(),  0);
    check("pending_disp", q_disp.size(), 0);
    check("pending_chg",  q_chg.size(),  0);
    check("pending_rej",  q_rej.size(),  0);
    check("pending_sold", q_sold.size(), 0);
    check("pending_inv",  q_inv.size(),  0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
